// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the scoreboarded register file: default word/address
// widths and the depth derivation used by the top and its read ports.
package reg_file_sb_pkg;

  localparam int DEF_DATA_WIDTH = 32'd16;
  localparam int DEF_ADDR_WIDTH = 32'd5;

  function automatic int reg_depth(input int addr_width);
    return int'(32'd1 << addr_width);
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: storage lookup, same-cycle write forwarding
// (port B over port A) and hardwired-zero handling for register 0.
module reg_file_rd_port
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_DEPTH  = reg_depth(ADDR_WIDTH),
  parameter int ZERO_REG   = 32'sd1,
  parameter int BYPASS     = 32'sd1
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem [REG_DEPTH],
  input  logic [REG_DEPTH-1:0]  pend,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a,
  input  logic [DATA_WIDTH-1:0] wr_data_a,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b,
  input  logic [DATA_WIDTH-1:0] wr_data_b,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_pend
);

  localparam bit ZERO_EN   = (ZERO_REG != 32'sd0);
  localparam bit BYPASS_EN = (BYPASS != 32'sd0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] data_s;

  // Select read data: zero register first, then forwarded write, then storage.
  always_comb begin
    data_s = mem[rd_addr];
    if (ZERO_EN && (rd_addr == ADDR_ZERO)) begin
      data_s = {DATA_WIDTH{1'b0}};
    end else if (BYPASS_EN && wr_en_b && (wr_addr_b == rd_addr)) begin
      data_s = wr_data_b;
    end else if (BYPASS_EN && wr_en_a && (wr_addr_a == rd_addr)) begin
      data_s = wr_data_a;
    end else begin
      data_s = mem[rd_addr];
    end
  end

  assign rd_data = data_s;
  // Pending status is the registered bit only; same-edge set/clear is not forwarded.
  assign rd_pend = pend[rd_addr];

endmodule

// File: rtl/reg_file_sb.sv
// Two-write / three-read register file with a per-register pending
// scoreboard and a registered count of outstanding producers.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 32'sd1,
  parameter int BYPASS     = 32'sd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  input  logic [ADDR_WIDTH-1:0] rd_addr_3,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2,
  output logic [DATA_WIDTH-1:0] rd_data_3,
  output logic                  rd_pend_1,
  output logic                  rd_pend_2,
  output logic                  rd_pend_3,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a,
  input  logic [DATA_WIDTH-1:0] wr_data_a,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b,
  input  logic [DATA_WIDTH-1:0] wr_data_b,
  input  logic                  sb_set_en,
  input  logic [ADDR_WIDTH-1:0] sb_set_addr,
  output logic [ADDR_WIDTH:0]   pend_count
);

  localparam int REG_DEPTH = reg_depth(ADDR_WIDTH);
  localparam bit ZERO_EN   = (ZERO_REG != 32'sd0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem_r [REG_DEPTH];
  logic [REG_DEPTH-1:0]  pend_r;
  logic [REG_DEPTH-1:0]  pend_nxt_s;
  logic [ADDR_WIDTH:0]   pend_count_r;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  wr_ok_a_s;
  logic                  wr_ok_b_s;
  logic                  set_ok_s;

  function automatic logic [ADDR_WIDTH:0] popcount(input logic [REG_DEPTH-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = {(ADDR_WIDTH+1){1'b0}};
    for (int i = 0; i < REG_DEPTH; i++) begin
      c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Qualified requests; gating with rst_n keeps forwarding quiet while in reset.
  assign wr_ok_a_s = rst_n && wr_en_a && !(ZERO_EN && (wr_addr_a == ADDR_ZERO));
  assign wr_ok_b_s = rst_n && wr_en_b && !(ZERO_EN && (wr_addr_b == ADDR_ZERO));
  assign set_ok_s  = rst_n && sb_set_en && !(ZERO_EN && (sb_set_addr == ADDR_ZERO));

  // Next pending bits: a set beats a same-edge clear from either write port.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int i = 0; i < REG_DEPTH; i++) begin
      pend_nxt_s[i] = (set_ok_s && (sb_set_addr == ADDR_WIDTH'(i))) ||
                      (pend_r[i] &&
                       !(wr_ok_a_s && (wr_addr_a == ADDR_WIDTH'(i))) &&
                       !(wr_ok_b_s && (wr_addr_b == ADDR_WIDTH'(i))));
    end
    count_nxt_s = popcount(pend_nxt_s);
  end

  // Storage array; port B is written last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (wr_ok_a_s) begin
        mem_r[wr_addr_a] <= wr_data_a;
      end
      if (wr_ok_b_s) begin
        mem_r[wr_addr_b] <= wr_data_b;
      end
    end
  end

  // Scoreboard bits and their registered population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r       <= {REG_DEPTH{1'b0}};
      pend_count_r <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      pend_r       <= pend_nxt_s;
      pend_count_r <= count_nxt_s;
    end
  end

  assign pend_count = pend_count_r;

  reg_file_rd_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .REG_DEPTH(REG_DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd_1 (
    .rd_addr(rd_addr_1), .mem(mem_r), .pend(pend_r),
    .wr_en_a(wr_ok_a_s), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_ok_b_s), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rd_data(rd_data_1), .rd_pend(rd_pend_1)
  );

  reg_file_rd_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .REG_DEPTH(REG_DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd_2 (
    .rd_addr(rd_addr_2), .mem(mem_r), .pend(pend_r),
    .wr_en_a(wr_ok_a_s), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_ok_b_s), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rd_data(rd_data_2), .rd_pend(rd_pend_2)
  );

  reg_file_rd_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .REG_DEPTH(REG_DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd_3 (
    .rd_addr(rd_addr_3), .mem(mem_r), .pend(pend_r),
    .wr_en_a(wr_ok_a_s), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_ok_b_s), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rd_data(rd_data_3), .rd_pend(rd_pend_3)
  );

endmodule
